// File: rtl/biu_mem2ahb.sv
`default_nettype none
// ============================================================================
// Module      : biu_mem2ahb
// Description : CPU memory-port to AHB3-Lite master bridge. Requests pass a
//               one-cycle alignment check stage, are buffered in a small
//               in-order queue and issued as pipelined SINGLE transfers.
//               Acks, errors and read data return in issue order.
// Revision    : 1.0 - initial release
// ============================================================================
module biu_mem2ahb #(
  parameter int XLEN           = 32,
  parameter int PHYS_ADDR_SIZE = XLEN,
  parameter int DEPTH          = 2
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  // CPU side
  input  logic                      mem_req,
  input  logic [XLEN-1:0]           mem_adr,
  input  logic [XLEN-1:0]           mem_d,
  input  logic                      mem_we,
  input  logic [XLEN/8-1:0]         mem_be,
  output logic [XLEN-1:0]           mem_q,
  output logic                      mem_ack,
  output logic                      mem_err,
  output logic                      mem_misaligned,
  output logic                      mem_stall,
  // AHB side
  output logic                      HSEL,
  output logic [PHYS_ADDR_SIZE-1:0] HADDR,
  output logic [XLEN-1:0]           HWDATA,
  input  logic [XLEN-1:0]           HRDATA,
  output logic                      HWRITE,
  output logic [2:0]                HSIZE,
  output logic [2:0]                HBURST,
  output logic [3:0]                HPROT,
  output logic [1:0]                HTRANS,
  output logic                      HMASTLOCK,
  input  logic                      HREADY,
  input  logic                      HRESP
);

  localparam int BW   = XLEN / 8;
  localparam int OFFW = $clog2(BW);
  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_DATA = 3'd2,
    ST_DATA      = 3'd3,
    ST_ERR1      = 3'd4,
    ST_ERR2      = 3'd5
  } bus_state_e;

  // --------------------------------------------------------------------------
  // Check stage
  // --------------------------------------------------------------------------
  logic                chk_vld_q, chk_vld_d;
  logic [XLEN-1:0]     chk_adr_q, chk_adr_d;
  logic [XLEN-1:0]     chk_d_q,   chk_d_d;
  logic                chk_we_q,  chk_we_d;
  logic [BW-1:0]       chk_be_q,  chk_be_d;

  logic [3:0]          be_cnt;
  logic [3:0]          be_off;
  logic [BW-1:0]       be_exp;
  logic                be_ok;
  logic                chk_aligned;
  logic [2:0]          chk_size;
  logic                push;

  // Queue
  logic [PHYS_ADDR_SIZE-1:0] q_adr_q  [DEPTH];
  logic [PHYS_ADDR_SIZE-1:0] q_adr_d  [DEPTH];
  logic [XLEN-1:0]           q_dat_q  [DEPTH];
  logic [XLEN-1:0]           q_dat_d  [DEPTH];
  logic                      q_we_q   [DEPTH];
  logic                      q_we_d   [DEPTH];
  logic [2:0]                q_size_q [DEPTH];
  logic [2:0]                q_size_d [DEPTH];
  logic [PTRW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]           count_q,  count_d;
  logic [CNTW:0]             occupancy;

  // Bus side
  bus_state_e                state_q, state_d;
  logic                      addr_ph, data_ph, err_first, issue, pop, done;
  logic                      dph_we_q, dph_we_d;
  logic [XLEN-1:0]           dph_d_q,  dph_d_d;
  logic                      ack_q, ack_d;
  logic                      err_q, err_d;
  logic [XLEN-1:0]           mem_q_q, mem_q_d;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    if (p == PTRW'(DEPTH - 1)) return '0;
    return p + PTRW'(1);
  endfunction

  // Stall when the queue plus the check stage already hold DEPTH requests
  always_comb begin
    occupancy = {1'b0, count_q} + {{CNTW{1'b0}}, chk_vld_q};
    mem_stall = (occupancy == (CNTW+1)'(DEPTH));
  end

  // Capture an accepted CPU request into the check stage
  always_comb begin
    chk_vld_d = mem_req && !mem_stall;
    chk_adr_d = chk_adr_q;
    chk_d_d   = chk_d_q;
    chk_we_d  = chk_we_q;
    chk_be_d  = chk_be_q;
    if (chk_vld_d) begin
      chk_adr_d = mem_adr;
      chk_d_d   = mem_d;
      chk_we_d  = mem_we;
      chk_be_d  = mem_be;
    end
  end

  // Byte-enable must be a contiguous, naturally aligned mask at the address offset
  always_comb begin
    be_cnt = 4'd0;
    for (int i = 0; i < BW; i++) be_cnt = be_cnt + {3'd0, chk_be_q[i]};
    be_off = 4'(chk_adr_q[OFFW-1:0]);
    be_exp = '0;
    for (int i = 0; i < BW; i++)
      be_exp[i] = (4'(i) >= be_off) && (4'(i) < be_off + be_cnt);
    be_ok    = 1'b0;
    chk_size = 3'd0;
    case (be_cnt)
      4'd1: begin be_ok = 1'b1;                      chk_size = 3'd0; end
      4'd2: begin be_ok = (be_off[0] == 1'b0);       chk_size = 3'd1; end
      4'd4: begin be_ok = (be_off[1:0] == 2'b00);    chk_size = 3'd2; end
      4'd8: begin be_ok = (be_off[2:0] == 3'b000);   chk_size = 3'd3; end
      default: begin be_ok = 1'b0;                   chk_size = 3'd0; end
    endcase
    chk_aligned    = be_ok && (chk_be_q == be_exp);
    mem_misaligned = chk_vld_q && !chk_aligned;
    push           = chk_vld_q && chk_aligned;
  end

  // Bus phase decode; an error's first cycle cancels the overlapping address phase
  always_comb begin
    addr_ph   = (state_q == ST_ADDR) || (state_q == ST_ADDR_DATA);
    data_ph   = (state_q == ST_ADDR_DATA) || (state_q == ST_DATA);
    err_first = data_ph && !HREADY && HRESP;
    issue     = addr_ph && !err_first;
    pop       = issue && HREADY;
    done      = data_ph && HREADY;
  end

  // Queue storage and pointers
  always_comb begin
    q_adr_d  = q_adr_q;
    q_dat_d  = q_dat_q;
    q_we_d   = q_we_q;
    q_size_d = q_size_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      q_adr_d[wr_ptr_q]  = chk_adr_q[PHYS_ADDR_SIZE-1:0];
      q_dat_d[wr_ptr_q]  = chk_d_q;
      q_we_d[wr_ptr_q]   = chk_we_q;
      q_size_d[wr_ptr_q] = chk_size;
      wr_ptr_d           = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    count_d = count_q + CNTW'(push) - CNTW'(pop);
  end

  // Bus FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (count_d != '0) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (pop) state_d = (count_d != '0) ? ST_ADDR_DATA : ST_DATA;
      end
      ST_ADDR_DATA: begin
        if (err_first)   state_d = ST_ERR1;
        else if (HREADY) state_d = (count_d != '0) ? ST_ADDR_DATA : ST_DATA;
      end
      ST_DATA: begin
        if (err_first)            state_d = ST_ERR1;
        else if (HREADY)          state_d = (count_d != '0) ? ST_ADDR : ST_IDLE;
        else if (count_d != '0)   state_d = ST_ADDR_DATA;
      end
      ST_ERR1: begin
        if (HREADY) state_d = ST_ERR2;
      end
      ST_ERR2: begin
        state_d = (count_d != '0) ? ST_ADDR : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Data-phase context and CPU completion strobes
  always_comb begin
    dph_we_d = dph_we_q;
    dph_d_d  = dph_d_q;
    if (pop) begin
      dph_we_d = q_we_q[rd_ptr_q];
      dph_d_d  = q_dat_q[rd_ptr_q];
    end
    ack_d   = done && !HRESP;
    err_d   = (done && HRESP) || ((state_q == ST_ERR1) && HREADY);
    mem_q_d = (done && !HRESP && !dph_we_q) ? HRDATA : mem_q_q;
  end

  // State registers, asynchronously cleared
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      chk_vld_q <= 1'b0;
      chk_adr_q <= '0;
      chk_d_q   <= '0;
      chk_we_q  <= 1'b0;
      chk_be_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_adr_q[i]  <= '0;
        q_dat_q[i]  <= '0;
        q_we_q[i]   <= 1'b0;
        q_size_q[i] <= 3'd0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      dph_we_q <= 1'b0;
      dph_d_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      mem_q_q  <= '0;
    end else begin
      chk_vld_q <= chk_vld_d;
      chk_adr_q <= chk_adr_d;
      chk_d_q   <= chk_d_d;
      chk_we_q  <= chk_we_d;
      chk_be_q  <= chk_be_d;
      q_adr_q   <= q_adr_d;
      q_dat_q   <= q_dat_d;
      q_we_q    <= q_we_d;
      q_size_q  <= q_size_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      dph_we_q  <= dph_we_d;
      dph_d_q   <= dph_d_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      mem_q_q   <= mem_q_d;
    end
  end

  // Output drive: address-phase signals come from the queue head
  always_comb begin
    HTRANS    = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
    HSEL      = issue;
    HADDR     = addr_ph ? q_adr_q[rd_ptr_q]  : '0;
    HWRITE    = addr_ph ? q_we_q[rd_ptr_q]   : 1'b0;
    HSIZE     = addr_ph ? q_size_q[rd_ptr_q] : 3'd0;
    HWDATA    = dph_d_q;
    HBURST    = 3'b000;
    HPROT     = 4'b0011;
    HMASTLOCK = 1'b0;
    mem_q     = mem_q_q;
    mem_ack   = ack_q;
    mem_err   = err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_biu_mem2ahb.sv
`default_nettype none
// ============================================================================
// Module      : tb_biu_mem2ahb
// Description : Scoreboard bench for biu_mem2ahb with a reactive AHB slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_biu_mem2ahb;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        mem_req;
  logic [31:0] mem_adr, mem_d;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_q;
  logic        mem_ack, mem_err, mem_misaligned, mem_stall;
  logic        HSEL;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK, HREADY, HRESP;

  biu_mem2ahb #(.XLEN(32), .PHYS_ADDR_SIZE(32), .DEPTH(2)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .mem_req(mem_req), .mem_adr(mem_adr), .mem_d(mem_d), .mem_we(mem_we), .mem_be(mem_be),
    .mem_q(mem_q), .mem_ack(mem_ack), .mem_err(mem_err), .mem_misaligned(mem_misaligned),
    .mem_stall(mem_stall), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  typedef struct { logic [31:0] adr; logic we; logic [2:0] size; logic [31:0] d; } addr_t;
  typedef struct { logic is_err; logic chk_q; logic [31:0] q; } resp_t;

  addr_t       exp_addr[$];
  resp_t       exp_resp[$];
  logic [31:0] exp_mis_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // slave configuration and state
  int          ws = 0;
  logic        err_on = 1'b0;
  logic [31:0] err_addr = 32'h0;
  logic        dp_active = 1'b0, dp_err = 1'b0;
  logic [31:0] dp_addr = 32'h0;
  int          dp_cyc = 0;
  logic [1:0]  s_trans;
  logic        s_ready, s_rst;
  logic [31:0] s_addr;

  // monitor state
  logic  mon_dp = 1'b0;
  addr_t mon_e, m_a;
  resp_t m_r;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] slave_rdata(input logic [31:0] a);
    if (a == 32'h203) return 32'h1200_0000;
    return {16'hC0DE, a[15:0]};
  endfunction

  // AHB slave: ws wait states per data phase, optional two-cycle ERROR
  initial begin
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    forever begin
      @(negedge HCLK);
      s_trans = HTRANS; s_ready = HREADY; s_addr = HADDR; s_rst = !HRESETn;
      @(posedge HCLK); #1;
      if (s_rst || !HRESETn) dp_active = 1'b0;
      else begin
        if (dp_active && s_ready) dp_active = 1'b0;
        if (s_trans == 2'b10 && s_ready) begin
          dp_active = 1'b1; dp_addr = s_addr; dp_cyc = 0;
          dp_err = err_on && (s_addr == err_addr);
          if (dp_err) err_on = 1'b0;
        end
      end
      if (dp_active) begin
        if (dp_cyc < ws) begin HREADY = 1'b0; HRESP = 1'b0; end
        else if (dp_err && dp_cyc == ws) begin HREADY = 1'b0; HRESP = 1'b1; end
        else begin HREADY = 1'b1; HRESP = dp_err; HRDATA = slave_rdata(dp_addr); end
        dp_cyc++;
      end else begin
        HREADY = 1'b1; HRESP = 1'b0;
      end
    end
  end

  // Scoreboard monitor
  initial begin
    forever begin
      @(negedge HCLK);
      if (!HRESETn) mon_dp = 1'b0;
      else begin
        if (mem_ack || mem_err) begin
          chk("resp_expected", exp_resp.size() != 0, 1);
          if (exp_resp.size() != 0) begin
            m_r = exp_resp.pop_front();
            chk("resp_kind_err", mem_err, m_r.is_err);
            chk("resp_kind_ack", mem_ack, !m_r.is_err);
            if (m_r.chk_q) chk("mem_q", mem_q, m_r.q);
          end
        end
        if (mem_misaligned) begin
          chk("misaligned_expected", exp_mis_q.size() != 0, 1);
          if (exp_mis_q.size() != 0) void'(exp_mis_q.pop_front());
        end
        if (mon_dp && HREADY) begin
          if (mon_e.we) chk("hwdata", HWDATA, mon_e.d);
          mon_dp = 1'b0;
        end
        if (HTRANS == 2'b10 && HREADY) begin
          chk("addr_expected", exp_addr.size() != 0, 1);
          if (exp_addr.size() != 0) begin
            m_a = exp_addr.pop_front();
            chk("haddr", HADDR, m_a.adr);
            chk("hwrite", HWRITE, m_a.we);
            chk("hsize", HSIZE, m_a.size);
            chk("hsel", HSEL, 1);
            chk("hburst_hprot_lock", {HBURST, HPROT, HMASTLOCK}, {3'b000, 4'b0011, 1'b0});
            mon_e = m_a; mon_dp = 1'b1;
          end
        end
      end
    end
  end

  // Issue one request; caller is at posedge+1. Returns at next posedge+1.
  task automatic send(input logic [31:0] adr, input logic we, input logic [3:0] be,
                      input logic [31:0] d, input logic mis, input logic [2:0] size,
                      input logic is_err, input logic [31:0] q);
    addr_t a; resp_t r; int guard;
    guard = 0;
    while (mem_stall && guard < 200) begin @(posedge HCLK); #1; guard++; end
    chk("stall_wait", mem_stall, 0);
    if (mis) exp_mis_q.push_back(adr);
    else begin
      a.adr = adr; a.we = we; a.size = size; a.d = d;
      r.is_err = is_err; r.chk_q = !we && !is_err; r.q = q;
      exp_addr.push_back(a); exp_resp.push_back(r);
    end
    mem_req = 1'b1; mem_adr = adr; mem_we = we; mem_be = be; mem_d = d;
    @(posedge HCLK); #1;
    mem_req = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_resp.size() + exp_addr.size() + exp_mis_q.size()) != 0 && guard < 300) begin
      @(posedge HCLK); guard++;
    end
    chk("drain_pending", exp_resp.size() + exp_addr.size() + exp_mis_q.size(), 0);
    repeat (3) @(posedge HCLK);
    #1;
  endtask

  task automatic write_timing();
    send(32'h100, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, 3'd2, 1'b0, 32'h0);
    @(negedge HCLK); chk("c1_misaligned", mem_misaligned, 0); chk("c1_htrans", HTRANS, 0);
    @(negedge HCLK); chk("c2_htrans", HTRANS, 2'b10); chk("c2_haddr", HADDR, 32'h100);
    chk("c2_hsize", HSIZE, 3'd2); chk("c2_hwrite", HWRITE, 1);
    @(negedge HCLK); chk("c3_hwdata", HWDATA, 32'hDEADBEEF); chk("c3_htrans", HTRANS, 0);
    @(negedge HCLK); chk("c4_ack", mem_ack, 1);
    @(negedge HCLK); chk("c5_ack_pulse", mem_ack, 0);
    @(posedge HCLK); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_htrans"}, HTRANS, 0);
    chk({tag, "_hsel"}, HSEL, 0);
    chk({tag, "_haddr"}, HADDR, 0);
    chk({tag, "_hwdata"}, HWDATA, 0);
    chk({tag, "_hprot"}, HPROT, 4'b0011);
    chk({tag, "_cpu_out"}, {mem_ack, mem_err, mem_misaligned, mem_stall, mem_q}, 0);
  endtask

  // Watchdog
  initial begin
    repeat (20000) @(posedge HCLK);
    n_errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn = 1'b0; mem_req = 1'b0; mem_adr = 32'h0; mem_d = 32'h0; mem_we = 1'b0; mem_be = 4'h0;
    repeat (3) @(posedge HCLK);
    #1;
    check_reset_outputs("reset");
    @(negedge HCLK); HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // single write, exact timing
    write_timing();
    drain();

    // byte read at top lane
    send(32'h203, 1'b0, 4'h8, 32'h0, 1'b0, 3'd0, 1'b0, 32'h1200_0000);
    drain();

    // misaligned requests never reach the bus
    send(32'h001, 1'b0, 4'h6, 32'h0, 1'b1, 3'd0, 1'b0, 32'h0);
    @(negedge HCLK); chk("mis_c1", mem_misaligned, 1);
    for (int i = 0; i < 4; i++) begin @(negedge HCLK); chk("mis_htrans_idle", HTRANS, 0); end
    @(posedge HCLK); #1;
    send(32'h002, 1'b0, 4'h3, 32'h0, 1'b1, 3'd0, 1'b0, 32'h0);
    send(32'h000, 1'b0, 4'h0, 32'h0, 1'b1, 3'd0, 1'b0, 32'h0);
    send(32'h012, 1'b0, 4'hC, 32'h0, 1'b0, 3'd1, 1'b0, 32'hC0DE_0012);
    drain();

    // back-to-back reads with wait states
    ws = 2;
    send(32'h300, 1'b0, 4'hF, 32'h0, 1'b0, 3'd2, 1'b0, 32'hC0DE_0300);
    send(32'h304, 1'b0, 4'hF, 32'h0, 1'b0, 3'd2, 1'b0, 32'hC0DE_0304);
    @(negedge HCLK); chk("stall_at_two", mem_stall, 1);
    @(posedge HCLK); #1;
    send(32'h308, 1'b0, 4'hF, 32'h0, 1'b0, 3'd2, 1'b0, 32'hC0DE_0308);
    drain();
    ws = 0;

    // error on write cancels the pipelined read, which is reissued
    err_on = 1'b1; err_addr = 32'h400;
    send(32'h400, 1'b1, 4'hF, 32'hCAFEF00D, 1'b0, 3'd2, 1'b1, 32'h0);
    send(32'h404, 1'b0, 4'hF, 32'h0, 1'b0, 3'd2, 1'b0, 32'hC0DE_0404);
    @(negedge HCLK);
    @(negedge HCLK); chk("err_cancel_htrans", HTRANS, 0); chk("err_cancel_hsel", HSEL, 0);
    @(posedge HCLK); #1;
    drain();

    // asynchronous reset during a data phase
    ws = 3;
    send(32'h500, 1'b0, 4'hF, 32'h55AA55AA, 1'b0, 3'd2, 1'b0, 32'hC0DE_0500);
    @(posedge HCLK); @(posedge HCLK); @(negedge HCLK);
    chk("pre_reset_hwdata", HWDATA, 32'h55AA55AA);
    HRESETn = 1'b0;
    exp_resp.delete(); exp_addr.delete(); exp_mis_q.delete();
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(posedge HCLK);
    @(negedge HCLK); HRESETn = 1'b1;
    ws = 0;
    for (int i = 0; i < 8; i++) begin @(negedge HCLK); chk("no_ack_after_reset", mem_ack | mem_err, 0); end
    @(posedge HCLK); #1;
    write_timing();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
